// File: rtl/data_mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_bridge_pkg
//   Shared types and helpers for the data-memory bridge.
//   - bus_cmd_t       : one latched bus command (direction, word address, data)
//   - WAIT_CNT_MIN_W  : narrowest wait counter ever built
//   - word_addr()     : byte address -> word-aligned bus address
// -----------------------------------------------------------------------------
package data_mem_bridge_pkg;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_cmd_t;

   localparam int unsigned WAIT_CNT_MIN_W = 8;

   // Low two address bits are dropped silently; misaligned accesses are not trapped.
   function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
      return byte_addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/data_mem_bridge_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
//   Counts bus-wait cycles and flags the cycle in which the wait limit is hit.
//   Ports:
//     clk       in  clock
//     srst_i    in  synchronous active-high reset
//     load_i    in  clear the counter (entering the wait phase)
//     count_i   in  one wait cycle is elapsing this cycle
//     expire_o  out this wait cycle is the TIMEOUT-th one (never set if TIMEOUT=0)
// -----------------------------------------------------------------------------
module mem_wait_timer
   import data_mem_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic srst_i,
   input  logic load_i,
   input  logic count_i,
   output logic expire_o
);

   localparam int unsigned RAW_W = $clog2(TIMEOUT + 1);
   localparam int unsigned W     = (RAW_W < WAIT_CNT_MIN_W) ? WAIT_CNT_MIN_W : RAW_W;
   localparam bit          HAS_TIMEOUT = (TIMEOUT != 0);
   // cnt_q holds the number of wait cycles already completed, so the
   // TIMEOUT-th wait cycle is the one that sees TIMEOUT-1.
   localparam logic [W-1:0] LIMIT = HAS_TIMEOUT ? W'(TIMEOUT - 1) : '0;

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (count_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = HAS_TIMEOUT && count_i && (cnt_q == LIMIT);

endmodule

// File: rtl/data_mem_bridge.sv
// -----------------------------------------------------------------------------
// data_mem_bridge
//   Connects the single-cycle datapath's data-memory port to a multi-cycle
//   req/ack bus. Each load/store is latched, run on the bus, and its read data
//   returned; stall holds PC and register file until the access completes.
//   Ports:
//     clk, cpu_rst            clock, synchronous active-high reset
//     cpu_en                  debug run enable (not gated by stall)
//     mem_ren, mem_wen        load / store request from the controller
//     mem_addr, mem_dout      byte address, store data
//     mem_din                 load data to the write-back mux
//     stall                   1 = hold PC / regfile this cycle
//     bus_req/we/addr/wdata   bus command (req is a level)
//     bus_ack, bus_rdata      one-cycle completion pulse, read data
//     bus_err                 sticky timeout flag
//     stall_cnt               total stalled cycles (wraps)
// -----------------------------------------------------------------------------
module data_mem_bridge
   import data_mem_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        cpu_rst,
   input  logic        cpu_en,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_err,
   output logic [31:0] stall_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   bus_cmd_t    cmd_q, cmd_d;
   logic        req_q, req_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic access;
   logic timer_load;
   logic timer_count;
   logic timer_expire;

   assign access = cpu_en & (mem_ren | mem_wen);

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk      (clk),
      .srst_i   (cpu_rst),
      .load_i   (timer_load),
      .count_i  (timer_count),
      .expire_o (timer_expire)
   );

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      req_d       = req_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      stall_cnt_d = stall_cnt_q;
      stall       = 1'b0;
      timer_load  = 1'b0;
      timer_count = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Combinational stall so the PC does not advance past the access.
            stall = access;
            if (access) begin
               cmd_d.we    = mem_wen;   // ren & wen together is a write
               cmd_d.addr  = word_addr(mem_addr);
               cmd_d.wdata = mem_dout;
               req_d       = 1'b1;
               timer_load  = 1'b1;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            // cpu_en is deliberately ignored here: a started access always finishes.
            stall       = 1'b1;
            timer_count = 1'b1;
            if (bus_ack) begin
               req_d = 1'b0;
               if (!cmd_q.we) begin
                  rdata_d = bus_rdata;
               end
               state_d = S_DONE;
            end else if (timer_expire) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               rdata_d = ERR_DATA;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Core commits this cycle; stay here while the debugger halts the core.
            if (cpu_en) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase

      if (stall) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (cpu_rst) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         req_q       <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         req_q       <= req_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mem_din   = rdata_q;
   assign bus_req   = req_q;
   assign bus_we    = cmd_q.we;
   assign bus_addr  = cmd_q.addr;
   assign bus_wdata = cmd_q.wdata;
   assign bus_err   = err_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
module tb_data_mem_bridge;

   localparam int unsigned TO      = 4;
   localparam logic [31:0] ERRDATA = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        cpu_rst, cpu_en, mem_ren, mem_wen;
   logic [31:0] mem_addr, mem_dout, mem_din;
   logic        stall, bus_req, bus_we, bus_ack, bus_err;
   logic [31:0] bus_addr, bus_wdata, bus_rdata, stall_cnt;

   int checks   = 0;
   int failures = 0;

   // Reference expectations kept at transaction level.
   logic [31:0] exp_din;
   logic        exp_err;
   logic [31:0] exp_cnt;

   always #5 clk = ~clk;

   data_mem_bridge #(
      .TIMEOUT  (TO),
      .ERR_DATA (ERRDATA)
   ) dut (
      .clk       (clk),
      .cpu_rst   (cpu_rst),
      .cpu_en    (cpu_en),
      .mem_ren   (mem_ren),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .mem_din   (mem_din),
      .stall     (stall),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
      .bus_err   (bus_err),
      .stall_cnt (stall_cnt)
   );

   typedef struct {
      bit          ren;
      bit          wen;
      logic [31:0] addr;
      logic [31:0] dout;
      int          delay;      // ack in this WAIT cycle (1-based); > TO means never
      logic [31:0] rd;
      logic [31:0] exp_baddr;
      bit          exp_we;
      int          exp_stalls;
      logic [31:0] exp_din;
      bit          exp_err;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One memory instruction: starts in IDLE, returns during the DONE cycle.
   task automatic txn(input bit ren, input bit wen, input logic [31:0] addr,
                      input logic [31:0] dout, input int delay, input logic [31:0] rd,
                      input logic [31:0] e_baddr, input bit e_we, input int e_stalls,
                      input logic [31:0] e_din, input bit e_err, input string tag);
      int stalls;
      int waits;
      bit done;
      stalls = 0;
      waits  = 0;
      done   = 1'b0;
      @(negedge clk);
      cpu_en   = 1'b1;
      mem_ren  = ren;
      mem_wen  = wen;
      mem_addr = addr;
      mem_dout = dout;
      bus_ack  = 1'b0;
      #1;
      chk({tag, "_req_idle"}, {31'd0, bus_req}, 32'd0);
      for (int c = 0; c < 64; c++) begin
         if (c > 0) begin
            @(negedge clk);
            bus_ack = 1'b0;
            #1;
         end
         if (bus_req) begin
            waits++;
            if (waits == 1) begin
               chk({tag, "_addr"}, bus_addr, e_baddr);
               chk({tag, "_we"}, {31'd0, bus_we}, {31'd0, e_we});
               chk({tag, "_wdata"}, bus_wdata, dout);
            end
            if (waits == delay) begin
               bus_ack   = 1'b1;
               bus_rdata = rd;
            end
         end
         if (stall) begin
            stalls++;
         end else begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL %s_done: stall never cleared, got stalls=%0d expected %0d", tag, stalls, e_stalls);
      end
      exp_cnt = exp_cnt + 32'(e_stalls);
      exp_din = e_din;
      exp_err = e_err;
      chk({tag, "_stalls"}, 32'(stalls), 32'(e_stalls));
      chk({tag, "_din"}, mem_din, exp_din);
      chk({tag, "_err"}, {31'd0, bus_err}, {31'd0, exp_err});
      chk({tag, "_cnt"}, stall_cnt, exp_cnt);
      chk({tag, "_req_done"}, {31'd0, bus_req}, 32'd0);
      $display("txn %s ren=%0d wen=%0d addr=%08h delay=%0d stalls=%0d din=%08h err=%0d",
               tag, ren, wen, addr, delay, stalls, mem_din, bus_err);
   endtask

   // Idle cycles: first cycle always releases DONE, later ones may halt the core.
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cpu_en    = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         mem_ren   = cpu_en ? 1'b0 : 1'($urandom_range(0, 1));
         mem_wen   = cpu_en ? 1'b0 : 1'($urandom_range(0, 1));
         bus_ack   = 1'b0;
         bus_rdata = $urandom;
         #1;
         chk("idle_stall", {31'd0, stall}, 32'd0);
         chk("idle_req", {31'd0, bus_req}, 32'd0);
         chk("idle_cnt", stall_cnt, exp_cnt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d, r;
      bit          ren, wen;
      int          dly, es;

      tbl[0] = '{1, 0, 32'h0000_0104, 32'h0,         1,  32'h1234_5678, 32'h0000_0104, 0, 2, 32'h1234_5678, 0};
      tbl[1] = '{0, 1, 32'h0000_0203, 32'hCAFE_F00D, 4,  32'h0BAD_0BAD, 32'h0000_0200, 1, 5, 32'h1234_5678, 0};
      tbl[2] = '{1, 1, 32'h0000_1007, 32'h55AA_55AA, 1,  32'hFFFF_0000, 32'h0000_1004, 1, 2, 32'h1234_5678, 0};
      tbl[3] = '{1, 0, 32'h8000_0002, 32'h0,         3,  32'hA5A5_0001, 32'h8000_0000, 0, 4, 32'hA5A5_0001, 0};
      tbl[4] = '{1, 0, 32'h0000_0040, 32'h0,         99, 32'h1111_1111, 32'h0000_0040, 0, 5, 32'hDEAD_BEEF, 1};
      tbl[5] = '{1, 0, 32'h0000_0044, 32'h0,         4,  32'h2222_2222, 32'h0000_0044, 0, 5, 32'h2222_2222, 1};
      tbl[6] = '{1, 0, 32'h0000_0048, 32'h0,         1,  32'h3333_3333, 32'h0000_0048, 0, 2, 32'h3333_3333, 1};
      tbl[7] = '{1, 0, 32'h0000_004D, 32'h0,         1,  32'h4444_4444, 32'h0000_004C, 0, 2, 32'h4444_4444, 1};

      cpu_rst = 1'b1; cpu_en = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
      mem_addr = '0; mem_dout = '0; bus_ack = 1'b0; bus_rdata = '0;
      exp_din = '0; exp_err = 1'b0; exp_cnt = '0;
      repeat (3) @(negedge clk);
      cpu_rst = 1'b0;
      #1;
      chk("rst_req", {31'd0, bus_req}, 32'd0);
      chk("rst_we", {31'd0, bus_we}, 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_din", mem_din, 32'd0);
      chk("rst_err", {31'd0, bus_err}, 32'd0);
      chk("rst_cnt", stall_cnt, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);

      // Directed vectors, back-to-back with no idle gap.
      for (int i = 0; i < 8; i++) begin
         txn(tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].dout, tbl[i].delay, tbl[i].rd,
             tbl[i].exp_baddr, tbl[i].exp_we, tbl[i].exp_stalls, tbl[i].exp_din,
             tbl[i].exp_err, $sformatf("vec%0d", i));
      end

      // Timeout then a late ack during DONE and IDLE: must be ignored.
      txn(1, 0, 32'h0000_0080, 32'h0, 99, 32'h0, 32'h0000_0080, 0, 5, ERRDATA, 1, "late");
      bus_ack   = 1'b1;
      bus_rdata = 32'h7777_7777;
      @(negedge clk);
      mem_ren = 1'b0;
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      chk("late_din", mem_din, ERRDATA);
      chk("late_err", {31'd0, bus_err}, 32'd1);
      chk("late_req", {31'd0, bus_req}, 32'd0);
      chk("late_cnt", stall_cnt, exp_cnt);
      $display("txn late_ack din=%08h err=%0d", mem_din, bus_err);

      // Reset in the middle of a wait.
      @(negedge clk);
      cpu_en = 1'b1; mem_ren = 1'b1; mem_addr = 32'h0000_0300;
      @(negedge clk); #1;
      chk("rstmid_req_w1", {31'd0, bus_req}, 32'd1);
      @(negedge clk); #1;
      cpu_rst = 1'b1; mem_ren = 1'b0;
      @(negedge clk); #1;
      exp_cnt = '0; exp_din = '0; exp_err = 1'b0;
      chk("rstmid_req", {31'd0, bus_req}, 32'd0);
      chk("rstmid_stall", {31'd0, stall}, 32'd0);
      chk("rstmid_cnt", stall_cnt, exp_cnt);
      chk("rstmid_err", {31'd0, bus_err}, 32'd0);
      cpu_rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      chk("rstmid_ack_din", mem_din, 32'd0);
      chk("rstmid_ack_req", {31'd0, bus_req}, 32'd0);
      chk("rstmid_ack_stall", {31'd0, stall}, 32'd0);
      $display("txn reset_mid cnt=%0d err=%0d", stall_cnt, bus_err);

      // cpu_en dropped during WAIT: access completes and DONE holds.
      @(negedge clk);
      cpu_en = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_0500;
      #1;
      chk("halt_idle_stall", {31'd0, stall}, 32'd1);
      @(negedge clk); #1;
      chk("halt_w1_req", {31'd0, bus_req}, 32'd1);
      cpu_en = 1'b0;
      @(negedge clk); #1;
      chk("halt_w2_stall", {31'd0, stall}, 32'd1);
      bus_ack = 1'b1; bus_rdata = 32'h5A5A_0005;
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      exp_cnt = exp_cnt + 32'd3;
      exp_din = 32'h5A5A_0005;
      for (int k = 0; k < 3; k++) begin
         chk("halt_done_stall", {31'd0, stall}, 32'd0);
         chk("halt_done_din", mem_din, exp_din);
         chk("halt_done_req", {31'd0, bus_req}, 32'd0);
         @(negedge clk); #1;
      end
      chk("halt_cnt", stall_cnt, exp_cnt);
      cpu_en = 1'b1;
      #1;
      chk("halt_release_stall", {31'd0, stall}, 32'd0);
      @(negedge clk); #1;
      chk("halt_idle_again", {31'd0, stall}, 32'd1);
      mem_ren = 1'b0;
      #1;
      chk("halt_idle_quiet", {31'd0, stall}, 32'd0);
      $display("txn halt_in_wait din=%08h cnt=%0d", mem_din, stall_cnt);

      // Randomized transactions against the transaction-level model.
      for (int n = 0; n < 40; n++) begin
         idle($urandom_range(0, 2));
         ren = 1'($urandom_range(0, 1));
         wen = ren ? 1'($urandom_range(0, 1)) : 1'b1;
         a   = $urandom;
         d   = $urandom;
         r   = $urandom;
         dly = $urandom_range(1, 6);
         if (dly <= int'(TO)) begin
            es = dly + 1;
            txn(ren, wen, a, d, dly, r, a & 32'hFFFF_FFFC, wen, es,
                wen ? exp_din : r, exp_err, $sformatf("rnd%0d", n));
         end else begin
            es = int'(TO) + 1;
            txn(ren, wen, a, d, dly, r, a & 32'hFFFF_FFFC, wen, es,
                ERRDATA, 1'b1, $sformatf("rnd%0d", n));
         end
      end
      idle(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
